// File: rtl/branch_unit.sv
// Conditional branch resolver that reads the registered Z/N status flags.
// It waits out status-register writes, then issues a one-cycle PC-load pulse.
module branch_unit #(
    parameter int ADDR_WIDTH = 11,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  branch_reset,
    input  logic                  branch_req,
    input  logic [2:0]            branch_cond,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  status_Z_in,
    input  logic                  status_N_in,
    input  logic                  status_wr,
    output logic                  branch_busy,
    output logic                  branch_done,
    output logic                  branch_taken,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_target,
    output logic [CNT_WIDTH-1:0]  branch_taken_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        EVAL       = 2'd2,
        COMMIT     = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cond_q, cond_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  taken_q, taken_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  cond_hit;

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!branch_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a pending flag write delays evaluation
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (branch_req) begin
                    state_d = status_wr ? WAIT_FLAGS : EVAL;
                end
            end
            WAIT_FLAGS: begin
                if (!status_wr) begin
                    state_d = EVAL;
                end
            end
            EVAL:    state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Condition decode against the current status flags
    always_comb begin
        cond_hit = 1'b0;
        case (cond_q)
            3'b000:  cond_hit = status_Z_in;
            3'b001:  cond_hit = !status_Z_in;
            3'b010:  cond_hit = !status_Z_in && !status_N_in;
            3'b011:  cond_hit = !status_N_in;
            3'b100:  cond_hit = status_N_in;
            3'b101:  cond_hit = status_N_in || status_Z_in;
            3'b110:  cond_hit = 1'b1;
            default: cond_hit = 1'b0;
        endcase
    end

    // Datapath next values: latch request, register result, count taken
    always_comb begin
        cond_d   = cond_q;
        target_d = target_q;
        taken_d  = taken_q;
        cnt_d    = cnt_q;
        if (state_q == IDLE && branch_req) begin
            cond_d   = branch_cond;
            target_d = branch_target;
        end
        if (state_q == EVAL) begin
            taken_d = cond_hit;
        end
        if (state_q == COMMIT && taken_q && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Datapath registers, cleared by reset (aborts any request)
    always_ff @(posedge clock) begin
        if (!branch_reset) begin
            cond_q   <= '0;
            target_q <= '0;
            taken_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            cond_q   <= cond_d;
            target_q <= target_d;
            taken_q  <= taken_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decoded from state and held registers
    always_comb begin
        branch_busy        = (state_q != IDLE);
        branch_done        = (state_q == COMMIT);
        pc_load            = (state_q == COMMIT) && taken_q;
        branch_taken       = taken_q;
        pc_target          = target_q;
        branch_taken_count = cnt_q;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Consumer of the processor status register.
- Takes a conditional-branch request from the control unit and reads the registered Z/N flags (status register outputs).
- Resolves the condition through a small FSM and issues a one-cycle PC-load pulse with the latched target.
- Stalls while the status register is being written, so that a branch never evaluates stale flags.

Parameters:
ADDR_WIDTH, 11, width of branch target / PC
CNT_WIDTH, 8, width of saturating taken-branch counter

Ports:
clock  input  1  system clock, rising-edge
branch_reset  input  1  synchronous, active-low reset
branch_req  input  1  branch request strobe from control unit
branch_cond  input  3  condition code, sampled with branch_req
branch_target  input  ADDR_WIDTH  target address, sampled with branch_req
status_Z_in  input  1  Z flag from status register output
status_N_in  input  1  N flag from status register output
status_wr  input  1  status register write enable (flag-hazard indicator)
branch_busy  output  1  high while a request is in flight
branch_done  output  1  one-cycle pulse at resolution
branch_taken  output  1  result of the last resolved branch (held)
pc_load  output  1  one-cycle PC load pulse, only when taken
pc_target  output  ADDR_WIDTH  latched target; valid when pc_load=1
branch_taken_count  output  CNT_WIDTH  saturating count of taken branches

Behaviour:
- One clock; reset is synchronous and active-low (branch_reset=0 sampled at a rising clock edge). All state changes occur on the rising clock edge.
- Reset values: state IDLE; branch_busy, branch_done, branch_taken, pc_load = 0; pc_target = 0; branch_taken_count = 0.
- Reset mid-operation: the request is aborted, no pc_load or branch_done is issued, and the counter is cleared.
- Condition codes (Z, N read from status_*_in):
  - 000 EQ: Z
  - 001 NE: !Z
  - 010 GT: !Z & !N
  - 011 GE: !N
  - 100 LT: N
  - 101 LE: N | Z
  - 110 ALWAYS: 1
  - 111 reserved: 0 (never taken, still completes with done)
- FSM states: IDLE, WAIT_FLAGS, EVAL, COMMIT.
  - IDLE: when branch_req=1 at an edge, latch branch_cond and branch_target. Next state is WAIT_FLAGS if status_wr=1 at that same edge, else EVAL.
  - WAIT_FLAGS: remain while status_wr=1; go to EVAL at the first edge with status_wr=0.
  - EVAL: at the edge, sample status_Z_in/status_N_in and register the condition result into branch_taken. Go to COMMIT.
  - COMMIT: outputs are decoded from the state. branch_done=1; pc_load=branch_taken; counter increments if taken. Go to IDLE.
- branch_busy=1 in WAIT_FLAGS, EVAL and COMMIT; 0 in IDLE.
- Latency without hazard: request at edge t0, flags sampled at t1, done/pc_load high between t1 and t2. Each additional cycle of status_wr=1 adds one cycle.
- If status_wr=1 in EVAL, flags are still sampled. The status register holds its old value until that edge, so this is not a hazard.
- branch_req while busy (including in COMMIT) is ignored; no queueing.
- Back-to-back: a new request is accepted in IDLE at the edge right after COMMIT.
- Output holding:
  - branch_taken holds until the next EVAL.
  - pc_target holds the latched target after completion.
  - pc_load never asserts without branch_done.
- Counter saturates at 2^CNT_WIDTH-1; further taken branches leave it unchanged.
- Changes to branch_cond or branch_target after acceptance have no effect.

Test Plan:
- Reset: hold branch_reset=0 for 2 edges with branch_req=1 -> all outputs 0, busy=0. Release -> IDLE.
- EQ taken: Z=1, N=0, cond=000, target=0x155, one-cycle req -> done and pc_load high exactly 2 edges after req; pc_target=0x155; taken=1; count=1.
- GT not taken: Z=0, N=1, cond=010 -> done=1, pc_load=0, taken=0; count unchanged.
- Flag hazard: req with status_wr=1 for 2 cycles. Flags change from Z=0/N=1 to Z=1/N=0 at the last write; cond=000 -> done 4 edges after req; taken=1, reflecting the new flags.
- Busy/ignore and back-to-back:
  - Second req during EVAL with a different target -> ignored, pc_target unchanged.
  - req in the cycle after done -> accepted normally.
- Saturation and abort:
  - CNT_WIDTH=2, five ALWAYS branches -> count stops at 3.
  - Reset asserted in EVAL -> no done/pc_load; count=0.
